// File: rtl/axil_reg_access_arbiter.sv
// Two-requester round-robin sequencer that turns single-word register requests into AXI4-Lite
// transactions. Optional feature macro: AXIL_ARB_ADDR_CHECK_EN (reject out-of-range/misaligned addresses).
module axil_reg_access_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                  req_ack,
  output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t          state;
  logic            grant;
  logic            last_grant;
  logic            win;
  logic            win_write;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            addr_bad;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin pick: on a tie the requester that did not win last time goes first.
  always_comb begin
    win       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    win_write = req_write[win];
    win_addr  = win ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    win_wdata = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  end

`ifdef AXIL_ARB_ADDR_CHECK_EN
  assign addr_bad = (32'(win_addr) >= 32'(4 * C_NUM_REGS)) || (win_addr[1:0] != 2'b00);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      req_ack       <= 2'b00;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            grant <= win;
            if (addr_bad) begin
              rsp_resp  <= 2'b10;
              rsp_rdata <= '0;
              req_ack   <= onehot(win);
              state     <= DONE;
            end else if (win_write) begin
              m_axi_awaddr  <= win_addr;
              m_axi_wdata   <= win_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WADDR;
            end else begin
              m_axi_araddr  <= win_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RADDR;
            end
          end
        end
        // Address and data channels complete independently; leave once neither is pending.
        WADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            req_ack      <= onehot(grant);
            state        <= DONE;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            req_ack      <= onehot(grant);
            state        <= DONE;
          end
        end
        DONE: begin
          req_ack    <= 2'b00;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
